// File: rtl/clock_pkg.sv
// Shared constants for the time-of-day counter.
//   - Digit widths: units digits are 4-bit BCD; each tens digit is just wide
//     enough for its largest value (hours 0-2, minutes/seconds 0-5).
//   - Wrap limits in BCD form, compared directly by the digit-pair counters.
//   - to_bcd(): turns a binary 0-99 parameter into a packed two-digit BCD byte.
package clock_pkg;

  localparam int unsigned UNITS_W     = 4;
  localparam int unsigned HRS_TENS_W  = 2;
  localparam int unsigned MINS_TENS_W = 3;
  localparam int unsigned SECS_TENS_W = 3;

  localparam logic [7:0] SECS_MAX = 8'h59;
  localparam logic [7:0] MINS_MAX = 8'h59;
  localparam logic [7:0] HRS_MAX  = 8'h23;

  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_pair.sv
// Two-digit BCD counter with a programmable wrap value.
// Ports:
//   clk, reset      - clock, synchronous active-high reset (loads RST)
//   inc             - advance by one; rolls WRAP -> 00
//   clear           - force 00; wins over inc
//   tens, units     - registered digit outputs
//   carry           - high in the cycle where inc rolls WRAP -> 00
module bcd_pair
  import clock_pkg::*;
#(
  parameter int unsigned TENS_W = 3,
  parameter logic [7:0]  WRAP   = 8'h59,
  parameter logic [7:0]  RST    = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clear,
  output logic [TENS_W-1:0] tens,
  output logic [UNITS_W-1:0] units,
  output logic              carry
);

  logic [TENS_W-1:0]  tens_q, tens_d;
  logic [UNITS_W-1:0] units_q, units_d;
  logic               at_wrap;

  // The wrap is detected by comparing with the BCD limit, so the counter never
  // relies on binary overflow and works for any limit (59 or 23).
  assign at_wrap = (tens_q == WRAP[4 +: TENS_W]) && (units_q == WRAP[3:0]);
  assign carry   = inc && !clear && at_wrap;

  always_comb begin
    // NOTE: next-state defaults to the current state before any branch, so
    // every path assigns tens_d/units_d and no latch is inferred.
    tens_d  = tens_q;
    units_d = units_q;
    if (clear) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc) begin
      if (at_wrap) begin
        tens_d  = '0;
        units_d = '0;
      end else if (units_q == UNITS_W'(9)) begin
        tens_d  = tens_q + TENS_W'(1);
        units_d = '0;
      end else begin
        units_d = units_q + UNITS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples its pre-edge inputs regardless of evaluation order.
    if (reset) begin
      tens_q  <= RST[4 +: TENS_W];
      units_q <= RST[3:0];
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;

endmodule

// File: rtl/time_counter.sv
// Time-of-day register (HH:MM:SS as six BCD digits) for the VGA clock.
// Ports:
//   clk, reset                 - pixel clock, synchronous active-high reset
//   sec_tick                   - once-per-second strobe, advances seconds
//   adj_hrs/adj_mins/adj_secs  - button pulses: hours+1, minutes+1, seconds=00
//   hrs_d1..secs_d0            - registered BCD digits
//   changed                    - one-cycle strobe after any digit update
// Priority: an adjust on a field replaces the carry into that field, so each
// field moves by at most one step per cycle; reset beats everything.
module time_counter
  import clock_pkg::*;
#(
  parameter int unsigned RESET_HRS  = 0,
  parameter int unsigned RESET_MINS = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sec_tick,
  input  logic                   adj_hrs,
  input  logic                   adj_mins,
  input  logic                   adj_secs,
  output logic [HRS_TENS_W-1:0]  hrs_d1,
  output logic [UNITS_W-1:0]     hrs_d0,
  output logic [MINS_TENS_W-1:0] mins_d1,
  output logic [UNITS_W-1:0]     mins_d0,
  output logic [SECS_TENS_W-1:0] secs_d1,
  output logic [UNITS_W-1:0]     secs_d0,
  output logic                   changed
);

  localparam logic [7:0] HRS_RST  = to_bcd(RESET_HRS);
  localparam logic [7:0] MINS_RST = to_bcd(RESET_MINS);

  logic secs_carry;
  logic mins_carry;
  logic mins_inc;
  logic hrs_inc;
  logic hrs_carry_unused;  // 23 -> 00 leaves the block with nowhere to go
  logic changed_q, changed_d;

  // adj_secs clears seconds inside u_secs, which also suppresses its carry.
  assign mins_inc = adj_mins | secs_carry;
  // A minute adjust at 59 wraps minutes but must not bump hours.
  assign hrs_inc  = adj_hrs | (mins_carry & ~adj_mins);

  bcd_pair #(.TENS_W(SECS_TENS_W), .WRAP(SECS_MAX), .RST(8'h00)) u_secs (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_tick),
    .clear (adj_secs),
    .tens  (secs_d1),
    .units (secs_d0),
    .carry (secs_carry)
  );

  bcd_pair #(.TENS_W(MINS_TENS_W), .WRAP(MINS_MAX), .RST(MINS_RST)) u_mins (
    .clk   (clk),
    .reset (reset),
    .inc   (mins_inc),
    .clear (1'b0),
    .tens  (mins_d1),
    .units (mins_d0),
    .carry (mins_carry)
  );

  bcd_pair #(.TENS_W(HRS_TENS_W), .WRAP(HRS_MAX), .RST(HRS_RST)) u_hrs (
    .clk   (clk),
    .reset (reset),
    .inc   (hrs_inc),
    .clear (1'b0),
    .tens  (hrs_d1),
    .units (hrs_d0),
    .carry (hrs_carry_unused)
  );

  assign changed_d = sec_tick | adj_hrs | adj_mins | adj_secs;

  always_ff @(posedge clk) begin
    if (reset) changed_q <= 1'b0;
    else       changed_q <= changed_d;
  end

  assign changed = changed_q;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter (RESET_HRS=12, RESET_MINS=34).
// Every driven cycle pushes the expected digits/changed from an integer time
// model; a monitor pops and compares one entry per clock. Key scenarios also
// get direct checks against hand-computed constants.
module tb_time_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 1'b0;
  logic       adj_hrs = 1'b0;
  logic       adj_mins = 1'b0;
  logic       adj_secs = 1'b0;
  logic [1:0] hrs_d1;
  logic [3:0] hrs_d0;
  logic [2:0] mins_d1;
  logic [3:0] mins_d0;
  logic [2:0] secs_d1;
  logic [3:0] secs_d0;
  logic       changed;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] vec;
    logic        chg;
  } exp_t;

  exp_t sb[$];

  int mh = 0, mm = 0, ms = 0;

  time_counter #(.RESET_HRS(12), .RESET_MINS(34)) dut (
    .clk      (clk),
    .reset    (reset),
    .sec_tick (sec_tick),
    .adj_hrs  (adj_hrs),
    .adj_mins (adj_mins),
    .adj_secs (adj_secs),
    .hrs_d1   (hrs_d1),
    .hrs_d0   (hrs_d0),
    .mins_d1  (mins_d1),
    .mins_d0  (mins_d0),
    .secs_d1  (secs_d1),
    .secs_d0  (secs_d0),
    .changed  (changed)
  );

  always #5 clk = ~clk;

  logic [31:0] dut_vec;
  logic        in_range;
  assign dut_vec  = {12'b0, hrs_d1, hrs_d0, mins_d1, mins_d0, secs_d1, secs_d0};
  assign in_range = (hrs_d0 <= 4'd9) && (hrs_d1 <= 2'd2) &&
                    (hrs_d1 != 2'd2 || hrs_d0 <= 4'd3) &&
                    (mins_d1 <= 3'd5) && (mins_d0 <= 4'd9) &&
                    (secs_d1 <= 3'd5) && (secs_d0 <= 4'd9);

  function automatic logic [31:0] bcd_vec(input int h, input int m, input int s);
    return {12'b0, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and push what the DUT must
  // show after the following rising edge.
  task automatic cycle(input bit rst, input bit tick, input bit ah,
                       input bit am, input bit as_);
    bit min_step, hr_step;
    @(negedge clk);
    reset    = rst;
    sec_tick = tick;
    adj_hrs  = ah;
    adj_mins = am;
    adj_secs = as_;
    if (rst) begin
      mh = 12; mm = 34; ms = 0;
      sb.push_back('{bcd_vec(mh, mm, ms), 1'b0});
    end else begin
      min_step = am || (tick && !as_ && ms == 59);
      hr_step  = ah || (!am && tick && !as_ && ms == 59 && mm == 59);
      if (as_)       ms = 0;
      else if (tick) ms = (ms + 1) % 60;
      if (min_step)  mm = (mm + 1) % 60;
      if (hr_step)   mh = (mh + 1) % 24;
      sb.push_back('{bcd_vec(mh, mm, ms), tick | ah | am | as_});
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0);
  endtask

  // Direct check right after the edge that consumed the last cycle() call.
  task automatic anchor(input string tag, input int h, input int m, input int s,
                        input bit chg);
    @(posedge clk);
    #2;
    check({tag, "_time"}, dut_vec, bcd_vec(h, m, s));
    check({tag, "_chg"}, {31'b0, changed}, {31'b0, chg});
  endtask

  task automatic pulses(input int n, input bit tick, input bit ah,
                        input bit am, input bit as_);
    for (int i = 0; i < n; i++) begin
      cycle(0, tick, ah, am, as_);
      idle();
    end
  endtask

  // Scoreboard monitor: one expectation per clock, sampled 1 time unit
  // after the rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_digits", dut_vec, e.vec);
      check("sb_changed", {31'b0, changed}, {31'b0, e.chg});
      check("sb_range", {31'b0, in_range}, 32'd1);
    end
  end

  initial begin
    // Reset with a coincident sec_tick: tick must be ignored.
    cycle(1, 1, 0, 0, 0);
    anchor("reset", 12, 34, 0, 0);
    cycle(1, 0, 0, 0, 0);
    idle();
    anchor("post_reset", 12, 34, 0, 0);

    // 12:34:00 -> 23:59:58, then two ticks ten cycles apart.
    pulses(11, 0, 1, 0, 0);
    pulses(25, 0, 0, 1, 0);
    pulses(58, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    anchor("tick_59", 23, 59, 59, 1);
    for (int i = 0; i < 9; i++) idle();
    anchor("chg_low", 23, 59, 59, 0);
    cycle(0, 1, 0, 0, 0);
    anchor("full_wrap", 0, 0, 0, 1);
    idle();

    // 00:00:00 -> 10:59:59, then tick with adj_mins.
    pulses(10, 0, 1, 0, 0);
    pulses(59, 0, 0, 1, 0);
    pulses(59, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 0);
    anchor("adjmin_carry", 10, 0, 0, 1);
    idle();

    // 10:00:00 -> 05:20:37, then tick with adj_secs.
    pulses(19, 0, 1, 0, 0);
    pulses(20, 0, 0, 1, 0);
    pulses(37, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 1);
    anchor("adjsec_tick", 5, 20, 0, 1);
    idle();

    // 05:20:00 -> 09:00:00 (minute adjust wrap must not bump hours).
    pulses(4, 0, 1, 0, 0);
    pulses(40, 0, 0, 1, 0);
    anchor("adjmin_wrap", 9, 0, 0, 0);

    // 15 hour adjusts: 10..23, then 00.
    for (int i = 0; i < 15; i++) begin
      cycle(0, 0, 1, 0, 0);
      anchor("adj_hrs", (i < 14) ? 10 + i : 0, 0, 0, 1);
      idle();
    end

    // 3601 ticks from 00:00:00.
    for (int i = 0; i < 3601; i++) begin
      cycle(0, 1, 0, 0, 0);
      idle();
    end
    anchor("hour_run", 1, 0, 1, 0);

    // All three adjusts together, then tick+adjusts with reset.
    cycle(0, 0, 1, 1, 1);
    anchor("all_adj", 2, 1, 0, 1);
    idle();
    cycle(1, 1, 1, 1, 1);
    anchor("reset_prio", 12, 34, 0, 0);
    idle();
    idle();

    @(posedge clk);
    #3;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
